memory_b: RTL and testbench

//   Small synchronous register-file memory (default 4 x 8 bit), destination side of a

---
 rtl/memory_b.sv | 47 ++++
 tb/tb_memory_b.sv | 131 +++++++++++++
 2 files changed

// File: rtl/memory_b.sv
// memory_b: small register-file memory with one shared address port for
// write and read, and a registered read-data output.
// Optional feature: define MEMORYB_WRITE_THROUGH_EN to copy the write data
// onto DataOut during a write cycle. Without it, DataOut keeps its previous value.
module memory_b #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] AddrB,
  input  logic              WEB,
  input  logic [DATA_W-1:0] DataInB,
  output logic [DATA_W-1:0] DataOut
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Built from flops rather than RAM so that reset can clear every word.
  logic [DATA_W-1:0] mem [DEPTH];

  // Storage: the reset clears every word; otherwise a write updates only the addressed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (WEB) begin
      mem[AddrB] <= DataInB;
    end
  end

  // Read register: one cycle of latency, and DataOut is driven only from this flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DataOut <= '0;
    end else if (!WEB) begin
      DataOut <= mem[AddrB];
    end
`ifdef MEMORYB_WRITE_THROUGH_EN
    else begin
      DataOut <= DataInB;
    end
`endif
  end

endmodule

// File: tb/tb_memory_b.sv
// Self-checking bench for memory_b.
// Each cycle the bench drives a request and updates a reference model. It pushes the
// expected DataOut onto a queue. After the rising edge it pops that value and compares it.
module tb_memory_b;

  logic       clk;
  logic       rst_n;
  logic [1:0] AddrB;
  logic       WEB;
  logic [7:0] DataInB;
  logic [7:0] DataOut;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_mem [4];
  logic [7:0] m_out;
  logic [7:0] exp_q [$];
  string      tag_q [$];

  memory_b #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .AddrB   (AddrB),
    .WEB     (WEB),
    .DataInB (DataInB),
    .DataOut (DataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
    m_out = 8'h00;
  endtask

  // One request per cycle. The expected value is queued when the request is driven
  // and compared 1 ns after the edge that produces it.
  task automatic step(input logic we, input logic [1:0] a, input logic [7:0] d, input string tag);
    @(negedge clk);
    WEB = we; AddrB = a; DataInB = d;
    if (we) begin
      m_mem[a] = d;
`ifdef MEMORYB_WRITE_THROUGH_EN
      m_out = d;
`endif
    end else begin
      m_out = m_mem[a];
    end
    exp_q.push_back(m_out);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check(tag_q.pop_front(), DataOut, exp_q.pop_front());
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 4; i++) step(1'b0, 2'(i), 8'h00, $sformatf("%s_rd%0d", tag, i));
  endtask

  initial begin
    #20000;
    n_checks++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; WEB = 1'b0; AddrB = 2'd0; DataInB = 8'h00;
    model_reset();

    // Assert reset off a clock edge and check DataOut at once. Release it off an edge too.
    #2 rst_n = 1'b0;
    #1 check("reset_async", DataOut, 8'h00);
    #20 rst_n = 1'b1;
    read_all("after_reset");

    // Fill all four words, then read them back.
    step(1'b1, 2'd0, 8'h23, "fill_wr0");
    step(1'b1, 2'd1, 8'h87, "fill_wr1");
    step(1'b1, 2'd2, 8'hB7, "fill_wr2");
    step(1'b1, 2'd3, 8'hD7, "fill_wr3");
    read_all("fill");

    // A write cycle right after a read: DataOut holds the read value, or shows the
    // write data when write-through is enabled.
    step(1'b0, 2'd1, 8'h00, "hold_rd1");
    step(1'b1, 2'd2, 8'h55, "hold_wr2");
    step(1'b0, 2'd2, 8'h00, "hold_rd2_new");

    // Overwrite the same address twice; the last write wins and other words are untouched.
    step(1'b1, 2'd3, 8'hAA, "ovw_wrAA");
    step(1'b1, 2'd3, 8'h11, "ovw_wr11");
    step(1'b0, 2'd3, 8'h00, "ovw_rd3");
    step(1'b0, 2'd0, 8'h00, "ovw_rd0");
    step(1'b0, 2'd1, 8'h00, "ovw_rd1");
    step(1'b0, 2'd2, 8'h00, "ovw_rd2");

    // Pulse reset low for half a cycle in the middle of operation. All data is lost.
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("reset_mid_async", DataOut, 8'h00);
    #4 rst_n = 1'b1;
    read_all("after_mid_reset");

    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
